// File: rtl/seq_dbg_cmd_master.sv
// seq_dbg_cmd_master
// Avalon-MM master that issues one command into the sequencer core debug
// mailbox. It writes the parameter words, then the request word, then polls
// the status word until it reports done or error. It then returns the last
// status word that was read.
//
// Optional build macro: SEQ_DBG_TIMEOUT_EN
//   If defined, polling stops after TIMEOUT_POLLS non-done status reads and
//   the response is flagged with rsp_timeout. If undefined, polling has no
//   bound and rsp_timeout is tied low.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (accept on valid && ready)
//   cmd_code              value written to the request word
//   cmd_nparams           parameter count; values above MAX_PARAMS are clamped
//   cmd_params            parameter words, word i at [32i+31:32i]
//   rsp_valid             one-cycle completion pulse
//   rsp_status            last status word read
//   rsp_timeout           completion caused by the poll limit
//   avm_*                 Avalon-MM master interface (byte addressed)
module seq_dbg_cmd_master #(
  parameter int unsigned DBG_BASE      = 32'h153c0,
  parameter int          ADDR_W        = 20,
  parameter int          MAX_PARAMS    = 4,
  parameter int          POLL_GAP      = 16,
  parameter int          TIMEOUT_POLLS = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [31:0]               cmd_code,
  input  logic [2:0]                cmd_nparams,
  input  logic [32*MAX_PARAMS-1:0]  cmd_params,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_status,
  output logic                      rsp_timeout,
  output logic [ADDR_W-1:0]         avm_address,
  output logic                      avm_write,
  output logic                      avm_read,
  output logic [31:0]               avm_writedata,
  input  logic [31:0]               avm_readdata,
  input  logic                      avm_readdatavalid,
  input  logic                      avm_waitrequest
);

  localparam int IDX_W = $clog2(MAX_PARAMS + 1);
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [ADDR_W-1:0] REQ_ADDR  = ADDR_W'(DBG_BASE + 32'h8);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(DBG_BASE + 32'hC);
  localparam logic [ADDR_W-1:0] PAR_ADDR  = ADDR_W'(DBG_BASE + 32'h10);

  if (MAX_PARAMS < 1 || MAX_PARAMS > 7 || TIMEOUT_POLLS < 1) begin : g_bad_params
    $error("seq_dbg_cmd_master: MAX_PARAMS must be 1..7 and TIMEOUT_POLLS >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WR_PARAM, S_WR_CMD, S_POLL_RD, S_POLL_WAIT, S_GAP, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        np_q, np_d;
  logic [IDX_W-1:0]        np_clamped;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [31:0]             status_q, status_d;
  logic [31:0]             code_q;
  logic [32*MAX_PARAMS-1:0] params_q;
  logic [31:0]             wr_param;
  logic                    accept;
  logic                    poll_hit;

  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_DONE);
  assign rsp_status = status_q;
  assign accept     = cmd_valid && cmd_ready;

  always_comb begin
    if (32'(cmd_nparams) > 32'(MAX_PARAMS)) np_clamped = IDX_W'(MAX_PARAMS);
    else                                     np_clamped = IDX_W'(cmd_nparams);
  end

  // Select the parameter word addressed by the current index.
  always_comb begin
    wr_param = '0;
    for (int i = 0; i < MAX_PARAMS; i++) begin
      if (32'(idx_q) == i) wr_param = params_q[32*i +: 32];
    end
  end

`ifdef SEQ_DBG_TIMEOUT_EN
  localparam int POLL_W = $clog2(TIMEOUT_POLLS) + 1;
  logic [POLL_W-1:0] poll_q, poll_d, poll_inc;
  logic              timeout_q, timeout_d;

  // Saturating count of status words captured for this command.
  assign poll_inc    = (poll_q == '1) ? poll_q : poll_q + POLL_W'(1);
  assign poll_hit    = (poll_inc == POLL_W'(TIMEOUT_POLLS));
  assign rsp_timeout = timeout_q;

  always_comb begin
    poll_d    = poll_q;
    timeout_d = timeout_q;
    if (accept) timeout_d = 1'b0;
    if (state_q == S_WR_CMD && !avm_waitrequest) poll_d = '0;
    if (state_q == S_POLL_WAIT && avm_readdatavalid) begin
      poll_d = poll_inc;
      if (!avm_readdata[1] && poll_hit) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      poll_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      poll_q    <= poll_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign poll_hit    = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    np_d     = np_q;
    gap_d    = gap_q;
    status_d = status_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          idx_d   = '0;
          np_d    = np_clamped;
          state_d = (np_clamped != '0) ? S_WR_PARAM : S_WR_CMD;
        end
      end
      S_WR_PARAM: begin
        if (!avm_waitrequest) begin
          if (32'(idx_q) + 32'd1 == 32'(np_q)) state_d = S_WR_CMD;
          else                                  idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_WR_CMD: begin
        if (!avm_waitrequest) state_d = S_POLL_RD;
      end
      S_POLL_RD: begin
        if (!avm_waitrequest) state_d = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (avm_readdatavalid) begin
          status_d = avm_readdata;
          // Status code 2'b10 is done and 2'b11 is error. Both end the command.
          if (avm_readdata[1] || poll_hit) begin
            state_d = S_DONE;
          end else if (POLL_GAP == 0) begin
            state_d = S_POLL_RD;
          end else begin
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(POLL_GAP - 1)) state_d = S_POLL_RD;
        else                                gap_d   = gap_q + GAP_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs depend only on registered state. This keeps them stable
  // while the slave holds waitrequest.
  always_comb begin
    avm_write     = 1'b0;
    avm_read      = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    unique case (state_q)
      S_WR_PARAM: begin
        avm_write     = 1'b1;
        avm_address   = PAR_ADDR + (ADDR_W'(idx_q) << 2);
        avm_writedata = wr_param;
      end
      S_WR_CMD: begin
        avm_write     = 1'b1;
        avm_address   = REQ_ADDR;
        avm_writedata = code_q;
      end
      S_POLL_RD: begin
        avm_read    = 1'b1;
        avm_address = STAT_ADDR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      np_q     <= '0;
      gap_q    <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      np_q     <= np_d;
      gap_q    <= gap_d;
      status_q <= status_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      code_q   <= cmd_code;
      params_q <= cmd_params;
    end
  end

endmodule

// File: tb/tb_seq_dbg_cmd_master.sv
// Directed testbench for seq_dbg_cmd_master.
// A small Avalon slave model returns queued status words one cycle after each
// read is accepted. It can stall writes for 5 cycles or hold read responses.
// A monitor logs every completed transfer and checks the bus rules.
module tb_seq_dbg_cmd_master;

  localparam int MAXP = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [31:0]         cmd_code = '0;
  logic [2:0]          cmd_nparams = '0;
  logic [32*MAXP-1:0]  cmd_params = '0;
  logic                rsp_valid;
  logic [31:0]         rsp_status;
  logic                rsp_timeout;
  logic [19:0]         avm_address;
  logic                avm_write;
  logic                avm_read;
  logic [31:0]         avm_writedata;
  logic [31:0]         avm_readdata = '0;
  logic                avm_readdatavalid = 1'b0;
  logic                avm_waitrequest = 1'b0;

  seq_dbg_cmd_master #(
    .DBG_BASE(32'h153c0), .ADDR_W(20), .MAX_PARAMS(MAXP),
    .POLL_GAP(16), .TIMEOUT_POLLS(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_nparams(cmd_nparams), .cmd_params(cmd_params),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_timeout(rsp_timeout),
    .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Transfer logs and slave state
  logic [31:0] wr_addr [128];
  logic [31:0] wr_data [128];
  int          wr_cyc  [128];
  int          wr_n = 0;
  logic [31:0] rd_addr [64];
  int          rd_cyc  [64];
  int          rd_n = 0;
  int          rsp_n = 0;
  logic [31:0] stat [32];
  int          st_k = 0;
  bit          rd_pend = 0;
  bit          slv_hold = 0;
  bit          stall_en = 0;
  bit          prev_stall = 0;
  logic [19:0] prev_a = '0;
  logic [31:0] prev_d = '0;
  int          ws_cnt = 0;

  // Monitor: mid-cycle sampling of everything that will happen at the next edge.
  always @(negedge clk) begin
    if (prev_stall) begin
      check("wr_hold_strobe", 64'(avm_write), 64'd1);
      check("wr_hold_addr", 64'(avm_address), 64'(prev_a));
      check("wr_hold_data", 64'(avm_writedata), 64'(prev_d));
    end
    if (avm_read || avm_write) check("rd_wr_exclusive", 64'(avm_read && avm_write), 64'd0);
    if (avm_write && !avm_waitrequest && wr_n < 128) begin
      wr_addr[wr_n] = 32'(avm_address);
      wr_data[wr_n] = avm_writedata;
      wr_cyc[wr_n]  = cyc;
      wr_n++;
    end
    if (avm_read && !avm_waitrequest && rd_n < 64) begin
      check("one_read_outstanding", 64'(rd_pend), 64'd0);
      rd_addr[rd_n] = 32'(avm_address);
      rd_cyc[rd_n]  = cyc;
      rd_n++;
      rd_pend = 1'b1;
    end
    if (rsp_valid) rsp_n++;
    prev_stall = avm_write && avm_waitrequest;
    prev_a     = avm_address;
    prev_d     = avm_writedata;
  end

  // Slave: stalls each write for 5 cycles when enabled, answers reads one cycle later.
  always @(posedge clk) begin
    #1;
    if (prev_stall) ws_cnt++;
    else            ws_cnt = 0;
    avm_waitrequest   = stall_en && avm_write && (ws_cnt < 5);
    avm_readdatavalid = 1'b0;
    if (rd_pend && !slv_hold) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = stat[st_k];
      st_k++;
      rd_pend = 1'b0;
    end
  end

  task automatic wait_rsp(input string tag, input int maxc, output int rc);
    bit seen;
    seen = 1'b0;
    rc   = -1;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        rc   = cyc;
      end
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, rc, rc2, wb, rb, rsb;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_status", 64'(rsp_status), 64'd0);
    check("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
    check("rst_avm_read", 64'(avm_read), 64'd0);
    check("rst_avm_write", 64'(avm_write), 64'd0);
    check("rst_avm_address", 64'(avm_address), 64'd0);
    check("rst_avm_writedata", 64'(avm_writedata), 64'd0);
    reset = 1'b0;

    // T1: two params, done on first poll
    stat[0] = 32'h2;
    wb = wr_n; rb = rd_n;
    @(posedge clk); #1;
    c0 = cyc;
    cmd_code = 32'h5; cmd_nparams = 3'd2;
    cmd_params = {32'h0, 32'h0, 32'hB, 32'hA};
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("t1_ready_drop", 64'(cmd_ready), 64'd0);
    wait_rsp("t1_rsp_arrived", 200, rc);
    check("t1_rsp_cycle", 64'(rc - c0), 64'd6);
    check("t1_rsp_status", 64'(rsp_status), 64'h2);
    check("t1_rsp_timeout", 64'(rsp_timeout), 64'd0);
    check("t1_wr_count", 64'(wr_n - wb), 64'd3);
    check("t1_wr0_addr", 64'(wr_addr[wb]), 64'h153d0);
    check("t1_wr0_data", 64'(wr_data[wb]), 64'hA);
    check("t1_wr0_cycle", 64'(wr_cyc[wb] - c0), 64'd1);
    check("t1_wr1_addr", 64'(wr_addr[wb+1]), 64'h153d4);
    check("t1_wr1_data", 64'(wr_data[wb+1]), 64'hB);
    check("t1_req_addr", 64'(wr_addr[wb+2]), 64'h153c8);
    check("t1_req_data", 64'(wr_data[wb+2]), 64'h5);
    check("t1_req_cycle", 64'(wr_cyc[wb+2] - c0), 64'd3);
    check("t1_rd_count", 64'(rd_n - rb), 64'd1);
    check("t1_rd_addr", 64'(rd_addr[rb]), 64'h153cc);
    check("t1_rd_cycle", 64'(rd_cyc[rb] - c0), 64'd4);
    @(posedge clk); #1;
    check("t1_rsp_one_cycle", 64'(rsp_valid), 64'd0);
    check("t1_ready_back", 64'(cmd_ready), 64'd1);

    // T2: no params; busy, busy, error. Reads are 18 cycles apart:
    // 1 wait cycle for read data, then 16 gap cycles, then the next read.
    stat[1] = 32'h1; stat[2] = 32'h1; stat[3] = 32'h3;
    wb = wr_n; rb = rd_n;
    @(posedge clk); #1;
    c0 = cyc;
    cmd_code = 32'h1; cmd_nparams = 3'd0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_rsp("t2_rsp_arrived", 300, rc);
    check("t2_rsp_cycle", 64'(rc - c0), 64'd40);
    check("t2_rsp_status", 64'(rsp_status), 64'h3);
    check("t2_wr_count", 64'(wr_n - wb), 64'd1);
    check("t2_req_addr", 64'(wr_addr[wb]), 64'h153c8);
    check("t2_req_data", 64'(wr_data[wb]), 64'h1);
    check("t2_req_cycle", 64'(wr_cyc[wb] - c0), 64'd1);
    check("t2_rd_count", 64'(rd_n - rb), 64'd3);
    check("t2_rd0_cycle", 64'(rd_cyc[rb] - c0), 64'd2);
    check("t2_rd1_gap", 64'(rd_cyc[rb+1] - rd_cyc[rb]), 64'd18);
    check("t2_rd2_gap", 64'(rd_cyc[rb+2] - rd_cyc[rb+1]), 64'd18);
    check("t2_rd2_addr", 64'(rd_addr[rb+2]), 64'h153cc);

    // T3: 5-cycle waitrequest on every write
    stat[4] = 32'h2;
    stall_en = 1'b1;
    wb = wr_n; rb = rd_n;
    @(posedge clk); #1;
    @(posedge clk); #1;
    c0 = cyc;
    cmd_code = 32'h7; cmd_nparams = 3'd3;
    cmd_params = {32'h44, 32'h33, 32'h22, 32'h11};
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_rsp("t3_rsp_arrived", 300, rc);
    stall_en = 1'b0;
    check("t3_rsp_cycle", 64'(rc - c0), 64'd27);
    check("t3_wr_count", 64'(wr_n - wb), 64'd4);
    for (int i = 0; i < 3; i++) begin
      check("t3_par_addr", 64'(wr_addr[wb+i]), 64'h153d0 + 64'(4*i));
      check("t3_par_data", 64'(wr_data[wb+i]), 64'(32'h11 * (i + 1)));
      check("t3_par_cycle", 64'(wr_cyc[wb+i] - c0), 64'(6 * (i + 1)));
    end
    check("t3_req_addr", 64'(wr_addr[wb+3]), 64'h153c8);
    check("t3_req_data", 64'(wr_data[wb+3]), 64'h7);
    check("t3_req_cycle", 64'(wr_cyc[wb+3] - c0), 64'd24);
    check("t3_rd_count", 64'(rd_n - rb), 64'd1);

    // T4: reset while waiting for read data, then a late readdatavalid
    stat[5] = 32'h2;
    slv_hold = 1'b1;
    rb = rd_n;
    @(posedge clk); #1;
    cmd_code = 32'h9; cmd_nparams = 3'd0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 40 && rd_n == rb; i++) @(negedge clk);
    check("t4_read_issued", 64'(rd_n - rb), 64'd1);
    @(posedge clk); #1;
    check("t4_busy_before_reset", 64'(cmd_ready), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t4_ready_after_reset", 64'(cmd_ready), 64'd1);
    check("t4_no_read", 64'(avm_read), 64'd0);
    check("t4_no_write", 64'(avm_write), 64'd0);
    check("t4_addr_zero", 64'(avm_address), 64'd0);
    check("t4_no_rsp", 64'(rsp_valid), 64'd0);
    rsb = rsp_n;
    slv_hold = 1'b0;
    repeat (6) @(negedge clk);
    check("t4_late_rdv_sent", 64'(st_k), 64'd6);
    check("t4_late_rdv_no_rsp", 64'(rsp_n - rsb), 64'd0);
    check("t4_still_idle", 64'(cmd_ready), 64'd1);

    // T5: nparams clamped to 4; cmd_valid held across completion
    stat[6] = 32'h2; stat[7] = 32'h2;
    wb = wr_n;
    @(posedge clk); #1;
    c0 = cyc;
    cmd_code = 32'hC; cmd_nparams = 3'd7;
    cmd_params = {32'h4, 32'h3, 32'h2, 32'h1};
    cmd_valid = 1'b1;
    wait_rsp("t5_rsp1_arrived", 200, rc);
    check("t5_rsp1_cycle", 64'(rc - c0), 64'd8);
    @(posedge clk); #1;
    check("t5_ready_after_rsp", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("t5_second_accepted", 64'(cmd_ready), 64'd0);
    wait_rsp("t5_rsp2_arrived", 200, rc2);
    check("t5_rsp2_cycle", 64'(rc2 - c0), 64'd17);
    check("t5_wr_count", 64'(wr_n - wb), 64'd10);
    check("t5_second_first_wr", 64'(wr_cyc[wb+5] - rc), 64'd2);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        check("t5_par_addr", 64'(wr_addr[wb+5*k+i]), 64'h153d0 + 64'(4*i));
        check("t5_par_data", 64'(wr_data[wb+5*k+i]), 64'(i + 1));
      end
      check("t5_req_addr", 64'(wr_addr[wb+5*k+4]), 64'h153c8);
      check("t5_req_data", 64'(wr_data[wb+5*k+4]), 64'hC);
    end

`ifdef SEQ_DBG_TIMEOUT_EN
    // T6: status stays busy; limit of 4 polls
    for (int i = 8; i < 16; i++) stat[i] = 32'h1;
    wb = wr_n; rb = rd_n;
    @(posedge clk); #1;
    c0 = cyc;
    cmd_code = 32'h2; cmd_nparams = 3'd0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_rsp("t6_rsp_arrived", 400, rc);
    check("t6_rsp_cycle", 64'(rc - c0), 64'd58);
    check("t6_rd_count", 64'(rd_n - rb), 64'd4);
    check("t6_rsp_timeout", 64'(rsp_timeout), 64'd1);
    check("t6_rsp_status", 64'(rsp_status), 64'h1);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
